// File: rtl/neighbor_max_pool.sv
// Per-lane signed running max over NUM_NEIGHBOR difference vectors per group.
// Optional fused ReLU at output load: define NEIGHBOR_MAX_POOL_RELU_EN.
module neighbor_max_pool #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PE_ROW           = 16,
    parameter int NUM_NEIGHBOR     = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             group_start,
    input  logic                             din_valid,
    input  logic [INPUT_DATA_WIDTH*PE_ROW-1:0] din,
    output logic [INPUT_DATA_WIDTH*PE_ROW-1:0] dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             err_overrun,
    output logic                             err_short,
    input  logic                             err_clr
);

    localparam int W  = INPUT_DATA_WIDTH;
    localparam int VW = INPUT_DATA_WIDTH * PE_ROW;
    localparam int CW = $clog2(NUM_NEIGHBOR + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [W-1:0]  NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(NUM_NEIGHBOR - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [VW-1:0] acc;
    logic [VW-1:0] out_reg;
    logic [VW-1:0] mx;
    logic [VW-1:0] init_acc;
    logic [CW-1:0] init_cnt;
    logic          slot_free;
    logic          take;

    function automatic logic [VW-1:0] relu(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
`ifdef NEIGHBOR_MAX_POOL_RELU_EN
        for (int i = 0; i < PE_ROW; i++) begin
            if (v[i*W+W-1]) r[i*W +: W] = '0;
        end
`endif
        return r;
    endfunction

    always_comb begin
        mx = '0;
        for (int i = 0; i < PE_ROW; i++) begin
            if ($signed(din[i*W +: W]) > $signed(acc[i*W +: W]))
                mx[i*W +: W] = din[i*W +: W];
            else
                mx[i*W +: W] = acc[i*W +: W];
        end
    end

    // A start coinciding with a valid makes din the first sample of the new group.
    assign init_acc  = din_valid ? din : {PE_ROW{NEG}};
    assign init_cnt  = {{(CW-1){1'b0}}, din_valid};
    assign take      = dout_valid && dout_ready;
    assign slot_free = !dout_valid || dout_ready;
    assign dout      = out_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= {PE_ROW{NEG}};
            out_reg     <= '0;
            dout_valid  <= 1'b0;
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            if (take) dout_valid <= 1'b0;
            if (err_clr) begin
                err_overrun <= 1'b0;
                err_short   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (group_start) begin
                        acc   <= init_acc;
                        cnt   <= init_cnt;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (group_start) begin
                        if (cnt != '0) err_short <= 1'b1;
                        acc <= init_acc;
                        cnt <= init_cnt;
                    end else if (din_valid) begin
                        acc <= mx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            if (slot_free) begin
                                out_reg    <= relu(mx);
                                dout_valid <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (din_valid || group_start) err_overrun <= 1'b1;
                    if (take) begin
                        out_reg    <= relu(acc);
                        dout_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neighbor_max_pool.sv
// Bench for neighbor_max_pool: directed scenarios plus random traffic
// checked against a queue-based model of pending pooled results.
module tb_neighbor_max_pool;

    localparam int W = 8;
    localparam int P = 2;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           group_start = 1'b0;
    logic           din_valid = 1'b0;
    logic [W*P-1:0] din = '0;
    logic [W*P-1:0] dout;
    logic           dout_valid;
    logic           dout_ready = 1'b0;
    logic           err_overrun;
    logic           err_short;
    logic           err_clr = 1'b0;

    neighbor_max_pool #(
        .INPUT_DATA_WIDTH(W),
        .PE_ROW(P),
        .NUM_NEIGHBOR(N)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .group_start(group_start),
        .din_valid(din_valid),
        .din(din),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .err_overrun(err_overrun),
        .err_short(err_short),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: q holds results not yet accepted; q[0] is what dout must show.
    logic [W*P-1:0] q[$];
    bit             m_open;
    int             m_n;
    int             m_max[P];
    bit             m_ovr;
    bit             m_short;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W*P-1:0] pooled();
        logic [W*P-1:0] r;
        int v;
        for (int i = 0; i < P; i++) begin
            v = m_max[i];
`ifdef NEIGHBOR_MAX_POOL_RELU_EN
            if (v < 0) v = 0;
`endif
            r[i*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_open  = 0;
        m_n     = 0;
        m_ovr   = 0;
        m_short = 0;
    endtask

    task automatic model_edge();
        bit so = 0;
        bit ss = 0;
        bit pop;
        logic signed [W-1:0] s;
        pop = (q.size() > 0) && dout_ready;
        if (q.size() == 2) begin
            if (din_valid || group_start) so = 1;
            if (pop) void'(q.pop_front());
        end else begin
            if (pop) void'(q.pop_front());
            if (group_start) begin
                if (m_open && m_n > 0) ss = 1;
                m_open = 1;
                m_n = 0;
                for (int i = 0; i < P; i++) m_max[i] = -(1 << (W-1));
            end
            if (din_valid && m_open) begin
                for (int i = 0; i < P; i++) begin
                    s = din[i*W +: W];
                    if (int'(s) > m_max[i]) m_max[i] = int'(s);
                end
                m_n++;
                if (m_n == N) begin
                    q.push_back(pooled());
                    m_open = 0;
                end
            end
        end
        m_ovr   = (m_ovr && !err_clr) || so;
        m_short = (m_short && !err_clr) || ss;
    endtask

    task automatic compare();
        chk("valid", 32'(dout_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
        chk("overrun", 32'(err_overrun), 32'(m_ovr));
        chk("short", 32'(err_short), 32'(m_short));
    endtask

    task automatic step(input bit g, input bit d, input logic [W*P-1:0] x,
                        input bit r, input bit c);
        group_start = g;
        din_valid   = d;
        din         = x;
        dout_ready  = r;
        err_clr     = c;
        @(posedge clk);
        model_edge();
        #1;
        group_start = 1'b0;
        din_valid   = 1'b0;
        err_clr     = 1'b0;
        compare();
    endtask

    task automatic mid_reset();
        #2 rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_ovr", 32'(err_overrun), 32'd0);
        chk("rst_short", 32'(err_short), 32'd0);
        model_reset();
        #2 rstn = 1'b1;
    endtask

    logic [W*P-1:0] e;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", 32'(dout), 32'd0);
        compare();
        rstn = 1'b1;

        // Basic group
        step(1, 0, '0, 1, 0);
        step(0, 1, {8'hF8, 8'h05}, 1, 0);
        step(0, 1, {8'hFF, 8'hFD}, 1, 0);
        step(0, 1, {8'hFC, 8'h07}, 1, 0);
        step(0, 1, {8'hF7, 8'h02}, 1, 0);
`ifdef NEIGHBOR_MAX_POOL_RELU_EN
        e = 16'h0007;
`else
        e = 16'hFF07;
`endif
        chk("basic", 32'(dout), 32'(e));
        chk("basic_v", 32'(dout_valid), 32'd1);
        step(0, 0, '0, 1, 0);

        // All most-negative
        step(1, 0, '0, 1, 0);
        repeat (4) step(0, 1, 16'h8080, 1, 0);
`ifdef NEIGHBOR_MAX_POOL_RELU_EN
        e = 16'h0000;
`else
        e = 16'h8080;
`endif
        chk("allneg", 32'(dout), 32'(e));
        step(0, 0, '0, 1, 0);

        // Backpressure then overrun in HOLD
        step(1, 0, '0, 0, 0);
        repeat (4) step(0, 1, 16'h0303, 0, 0);
        step(1, 0, '0, 0, 0);
        repeat (4) step(0, 1, 16'h2266, 0, 0);
        chk("bp_no_ovr", 32'(err_overrun), 32'd0);
        chk("bp_held", 32'(dout), 32'h0303);
        step(0, 1, 16'h7F7F, 0, 0);
        step(1, 0, '0, 0, 0);
        chk("ovr_set", 32'(err_overrun), 32'd1);
        chk("ovr_hold", 32'(dout), 32'h0303);
        step(0, 0, '0, 1, 0);
        chk("bp_g2", 32'(dout), 32'h2266);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 1);
        chk("ovr_clr", 32'(err_overrun), 32'd0);

        // Short group
        step(1, 0, '0, 1, 0);
        step(0, 1, 16'h5050, 1, 0);
        step(0, 1, 16'h6060, 1, 0);
        step(1, 0, '0, 1, 0);
        repeat (4) step(0, 1, 16'h0101, 1, 0);
        chk("short_flag", 32'(err_short), 32'd1);
        chk("short_dout", 32'(dout), 32'h0101);

        // Simultaneous start and valid
        step(1, 1, 16'h1010, 1, 0);
        repeat (3) step(0, 1, 16'h0000, 1, 0);
        chk("simul", 32'(dout), 32'h1010);
        step(1, 0, '0, 1, 0);
        step(0, 1, 16'h0404, 1, 0);
        mid_reset();

        // Random traffic with varying backpressure
        for (int k = 0; k < 3000; k++) begin
            bit r;
            case ((k / 200) % 3)
                0: r = 1'b1;
                1: r = ($urandom_range(0, 1) == 1);
                default: r = ($urandom_range(0, 9) == 0);
            endcase
            step($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                 16'($urandom), r, $urandom_range(0, 30) == 0);
            if (k == 1500) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neighbor_max_pool.md
Name: neighbor_max_pool

Overview:
- Sits directly downstream of the per-lane neighbour-minus-centroid subtract stage.
- Consumes one PE_ROW-lane difference vector per done pulse and keeps a per-lane signed running maximum over NUM_NEIGHBOR vectors for the current centroid group.
- Emits the pooled vector through a valid/ready output register, so the next group can start accumulating while the previous result waits.

Parameters:
- INPUT_DATA_WIDTH, 8: width of one lane, two's-complement signed.
- PE_ROW, 16: number of lanes.
- NUM_NEIGHBOR, 16: vectors pooled per group; legal range 2..255.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous, active-low reset.
- group_start  input  1  one-cycle pulse that begins a new centroid group; driven by the same is_centroid strobe that feeds the subtract stage.
- din_valid  input  1  one-cycle pulse marking din valid; this is the subtract stage's done.
- din  input  INPUT_DATA_WIDTH*PE_ROW  difference vector; lane i is bits [W*i +: W].
- dout  output  INPUT_DATA_WIDTH*PE_ROW  pooled max vector, same lane packing.
- dout_valid  output  1  dout holds an unconsumed result.
- dout_ready  input  1  downstream accepts dout when dout_valid && dout_ready at a rising edge.
- err_overrun  output  1  sticky; an input was dropped because the block was in HOLD.
- err_short  output  1  sticky; a group was aborted before NUM_NEIGHBOR samples arrived.
- err_clr  input  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset: state=IDLE, cnt=0, all accumulator lanes = most-negative value (0x80 for W=8), out_reg=0, dout_valid=0, err_overrun=0, err_short=0.
- Compare and reduce: lane-wise signed max(acc[i], din[i]), no saturation or widening. dout = out_reg, driven straight from the register. cnt width is $clog2(NUM_NEIGHBOR+1).
- IDLE:
  - group_start: acc<=most-negative, cnt<=0, go to ACCUM.
  - din_valid without an open group: ignored, no error.
- ACCUM, din_valid:
  - acc<=max(acc,din), cnt<=cnt+1.
  - If cnt==NUM_NEIGHBOR-1, this is the final sample: let fin = max(acc,din).
  - If the output slot is free (dout_valid==0, or dout_valid&&dout_ready this cycle): out_reg<=fin, dout_valid<=1, go to IDLE.
  - Otherwise: acc<=fin, go to HOLD.
- ACCUM, group_start with cnt>0: err_short<=1, re-init acc/cnt, stay in ACCUM. group_start with cnt==0 re-inits silently.
- Simultaneous group_start and din_valid (any state except HOLD): group_start takes effect first; din becomes sample 1 of the new group (acc<=din, cnt<=1).
- HOLD:
  - dout_ready with dout_valid: out_reg<=acc, dout_valid stays 1, go to IDLE.
  - din_valid or group_start: err_overrun<=1, the event is dropped. If it coincides with the dout_ready transfer, it is still dropped.
- Output handshake: dout_valid drops the cycle after acceptance unless a new result loads the same edge. dout is stable while dout_valid && !dout_ready.
- Latency: the final din_valid at edge N gives dout_valid=1 and the result on dout after edge N, with a free slot.
- err_clr: clears both flags; a simultaneous set wins.
- Reset mid-group: everything returns to reset values and the partial group is discarded; there is no recovery state.
- The FSM uses exactly three states: IDLE, ACCUM, HOLD.

Optional Feature:
- Macro NEIGHBOR_MAX_POOL_RELU_EN.
- Defined: at the load into out_reg, any lane whose max is negative is forced to 0, giving a fused ReLU. Accumulation is unchanged.
- Undefined: the signed max passes through unchanged.

Test Plan:
- Basic group, NUM_NEIGHBOR=4, W=8, PE_ROW=2, dout_ready=1:
  - Stimulus: lane0 = 5,-3,7,2; lane1 = -8,-1,-4,-9.
  - Response: dout lane0=0x07, lane1=0xFF (-1), dout_valid for 1 cycle, starting the cycle after the 4th din_valid.
- All-negative lanes, RELU_EN undefined vs defined:
  - Stimulus: all inputs -128.
  - Response: dout=0x80 per lane undefined; 0x00 defined.
- Backpressure: hold dout_ready=0, run two groups back-to-back.
  - Group 1 sits in out_reg; group 2 enters HOLD.
  - Raise dout_ready: group 1, then group 2, each seen once; err_overrun=0.
- Overrun: while in HOLD, pulse din_valid and group_start.
  - Response: err_overrun=1, samples dropped, held result unchanged.
  - err_clr then returns the flag to 0.
- Short group: group_start, 2 samples, group_start, 4 samples of value 1.
  - Response: err_short=1; dout=0x01 per lane; the first 2 samples do not contribute.
- Simultaneous start+valid, then reset:
  - Stimulus: a group_start&din_valid cycle with din=0x10, followed by 3 samples of 0x00.
  - Response: dout=0x10.
  - Deasserting rstn mid-group: dout_valid=0 and both error flags 0 immediately.
